sobel_window_gen: RTL

//  Upstream feeder for the Sobel controller: accepts a raster-order pixel stream and emits every full
//  3x3 neighbourhood (interior pixels only, no border padding) as one flat 9-pixel window.

---
 rtl/sobel_window_gen.sv | 134 +++++++++++++
 1 files changed

// File: rtl/sobel_window_gen.sv
// ============================================================================
// sobel_window_gen -- raster pixel stream to 3x3 interior windows (two line buffers)
// Revision: 1.0
// ============================================================================
`default_nettype none

module sobel_window_gen #(
   parameter int data_size  = 24,
   parameter int IMG_WIDTH  = 64,
   parameter int IMG_HEIGHT = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [data_size-1:0]   pixel_in,
   input  logic                   pixel_valid,
   input  logic                   pixel_sof,
   output logic                   pixel_ready,
   output logic [9*data_size-1:0] win_data,
   output logic                   win_valid,
   input  logic                   win_ready,
   output logic                   frame_done
);

   localparam int c_CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int c_RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(IMG_WIDTH - 1);
   localparam logic [c_RW-1:0] c_ROW_LAST = c_RW'(IMG_HEIGHT - 1);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FILL = 2'd1, ST_ACTIVE = 2'd2} state_t;

   state_t                 state_q, state_d;
   logic [c_CW-1:0]        col_q, col_d, col_cur;
   logic [c_RW-1:0]        row_q, row_d, row_cur;
   logic [data_size-1:0]   win_q [0:2][0:2];
   logic [data_size-1:0]   win_d [0:2][0:2];
   logic [9*data_size-1:0] win_data_q, win_data_d;
   logic                   win_valid_q, win_valid_d;
   logic                   frame_done_q, frame_done_d;
   logic                   accept, in_frame;

   logic [data_size-1:0]   lb0_q [0:IMG_WIDTH-1];
   logic [data_size-1:0]   lb1_q [0:IMG_WIDTH-1];

   assign pixel_ready = !win_valid_q || win_ready;
   assign accept      = pixel_valid && pixel_ready;
   // In IDLE only a start-of-frame pixel enters the frame; others are swallowed.
   assign in_frame    = accept && ((state_q != ST_IDLE) || pixel_sof);
   assign col_cur     = pixel_sof ? '0 : col_q;
   assign row_cur     = pixel_sof ? '0 : row_q;

   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      row_d        = row_q;
      win_d        = win_q;
      win_data_d   = win_data_q;
      win_valid_d  = win_valid_q && !win_ready;
      frame_done_d = 1'b0;
      if (in_frame) begin
         for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
         end
         win_d[0][2] = lb0_q[col_cur];
         win_d[1][2] = lb1_q[col_cur];
         win_d[2][2] = pixel_in;
         if (pixel_sof) begin
            state_d = ST_FILL;
         end
         if (col_cur == c_COL_LAST) begin
            col_d = '0;
            row_d = row_cur + c_RW'(1);
            if (row_cur == c_RW'(1)) begin
               state_d = ST_ACTIVE;
            end
            if (row_cur == c_ROW_LAST) begin
               row_d        = '0;
               state_d      = ST_IDLE;
               frame_done_d = 1'b1;
            end
         end else begin
            col_d = col_cur + c_CW'(1);
            row_d = row_cur;
         end
         if ((row_cur >= c_RW'(2)) && (col_cur >= c_CW'(2))) begin
            win_valid_d = 1'b1;
            for (int r = 0; r < 3; r++) begin
               for (int c = 0; c < 3; c++) begin
                  win_data_d[(3*r+c)*data_size +: data_size] = win_d[r][c];
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         col_q        <= '0;
         row_q        <= '0;
         win_data_q   <= '0;
         win_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               win_q[r][c] <= '0;
            end
         end
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         win_q        <= win_d;
         win_data_q   <= win_data_d;
         win_valid_q  <= win_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Line-buffer RAM carries no reset; stale contents are overwritten before use.
   always_ff @(posedge clk) begin
      if (in_frame) begin
         lb0_q[col_cur] <= lb1_q[col_cur];
         lb1_q[col_cur] <= pixel_in;
      end
   end

   assign win_data   = win_data_q;
   assign win_valid  = win_valid_q;
   assign frame_done = frame_done_q;

endmodule

`default_nettype wire
